// File: rtl/cpu_pkg.sv
// Shared CPU constants: NOP encoding, default datapath widths and the
// pointer-width helper used by the queueing stages.
package cpu_pkg;

  localparam logic [31:0] INSTR_NOP      = 32'h0000_0000;
  localparam int          DEFAULT_DATA_W = 32;
  localparam int          DEFAULT_PC_W   = 32;
  localparam int          DEFAULT_DEPTH  = 4;

  // A single-entry queue still needs a 1-bit pointer, so never return 0.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

endpackage

// File: rtl/ibuf_mem.sv
// Instruction buffer storage: DEPTH words, synchronous write and
// asynchronous read, so the head entry is visible in the same cycle.
module ibuf_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and
  // count, so clearing the array would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// DEPTH-entry instruction queue between instruction memory and decode,
// with PC tags, valid/ready handshakes on both sides and redirect flush.
module instr_buffer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int PC_W   = DEFAULT_PC_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = ptr_width(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + PC_W;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_we;
  logic [ENTRY_W-1:0] w_rdata;

  // Ready depends on state only; a pop in the same cycle never frees a slot.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_we      = w_push & ~flush & rst;

  ibuf_mem #(
    .WIDTH  (ENTRY_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr),
    .wdata ({in_instr, in_pc}),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      // Redirect: drop everything, including a same-cycle push.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty buffer presents a NOP with a zero PC, like the old IR after reset.
  assign out_instr = out_valid ? w_rdata[ENTRY_W-1:PC_W] : DATA_W'(INSTR_NOP);
  assign out_pc    = out_valid ? w_rdata[PC_W-1:0]       : '0;
  assign count     = r_count;

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_instr_buffer;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_instr = '0;
  logic [PC_W-1:0]       in_pc = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [DATA_W-1:0]     out_instr;
  logic [PC_W-1:0]       out_pc;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t model[$];

  instr_buffer #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DATA_W-1:0] exp_instr;
    logic [PC_W-1:0]   exp_pc;
    exp_instr = (model.size() != 0) ? model[0].instr : '0;
    exp_pc    = (model.size() != 0) ? model[0].pc    : '0;
    check({tag, "_count"},     64'(count),     64'(model.size()));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(model.size() != 0));
    check({tag, "_in_ready"},  64'(in_ready),  64'(model.size() != DEPTH));
    check({tag, "_out_instr"}, 64'(out_instr), 64'(exp_instr));
    check({tag, "_out_pc"},    64'(out_pc),    64'(exp_pc));
  endtask

  // One clock: apply inputs, predict the handshake, advance model, check.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] ins,
                       input logic [PC_W-1:0] pc, input logic ordy,
                       input logic fl, input logic rs);
    logic   push;
    logic   pop;
    entry_t e;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    check({tag, "_pre_ready"}, 64'(in_ready), 64'(model.size() != DEPTH));
    push = v && (model.size() != DEPTH);
    pop  = ordy && (model.size() != 0);
    e.instr = ins;
    e.pc    = pc;
    @(posedge clk);
    if (!rs || fl) begin
      model.delete();
    end else begin
      if (pop)  void'(model.pop_front());
      if (push) model.push_back(e);
    end
    #1;
    check_state(tag);
  endtask

  task automatic push_word(input string tag, input logic [DATA_W-1:0] ins, input logic ordy);
    cycle(tag, 1'b1, ins, 32'h1000 + ins, ordy, 1'b0, 1'b1);
  endtask

  task automatic idle(input string tag, input logic ordy);
    cycle(tag, 1'b0, '0, '0, ordy, 1'b0, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] exp_seq [4];

    // 1. Reset held with a word offered: nothing stored.
    cycle("rst0", 1'b1, 32'h8C010004, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle("rst1", 1'b1, 32'h8C010004, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_out_instr_zero", 64'(out_instr), 64'h0);
    check("rst_count_zero",     64'(count),     64'h0);
    idle("post_rst", 1'b0);

    // 2. Single pass with one-cycle latency.
    cycle("single", 1'b1, 32'h20080005, 32'h00003000, 1'b0, 1'b0, 1'b1);
    check("single_instr", 64'(out_instr), 64'h20080005);
    check("single_pc",    64'(out_pc),    64'h00003000);
    idle("single_pop", 1'b1);
    check("single_empty_instr", 64'(out_instr), 64'h0);

    // 3. Fill, refuse when full, then pop two and wrap the pointers.
    for (int i = 1; i <= 4; i++) push_word("fill", DATA_W'(i), 1'b0);
    check("full_count", 64'(count),    64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    push_word("full_reject", 32'h5, 1'b0);
    idle("pop_a", 1'b1);
    idle("pop_b", 1'b1);
    push_word("wrap5", 32'h5, 1'b0);
    push_word("wrap6", 32'h6, 1'b0);
    exp_seq = '{32'h3, 32'h4, 32'h5, 32'h6};
    for (int i = 0; i < 4; i++) begin
      check("wrap_order", 64'(out_instr), 64'(exp_seq[i]));
      idle("drain", 1'b1);
    end

    // 4. Simultaneous push and pop at count=2.
    push_word("pp7", 32'h7, 1'b0);
    push_word("pp8", 32'h8, 1'b0);
    push_word("ppA", 32'hA, 1'b1);
    check("pp_count", 64'(count),     64'd2);
    check("pp_head",  64'(out_instr), 64'h8);
    idle("pp_pop", 1'b1);
    check("pp_next",  64'(out_instr), 64'hA);
    idle("pp_pop2", 1'b1);

    // 5. Flush with a same-cycle push: the pushed word is dropped.
    for (int i = 0; i < 3; i++) push_word("fl_fill", DATA_W'(32'h20 + i), 1'b0);
    cycle("flush", 1'b1, 32'hBEEF, 32'h4000, 1'b0, 1'b1, 1'b1);
    check("flush_instr", 64'(out_instr), 64'h0);
    push_word("after_flush", 32'hC, 1'b0);
    check("after_flush_head", 64'(out_instr), 64'hC);
    idle("fl_drain", 1'b1);

    // 6. Reset in mid-stream with decode ready.
    for (int i = 0; i < 3; i++) push_word("mr_fill", DATA_W'(32'h30 + i), 1'b0);
    cycle("mid_rst", 1'b1, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0);
    push_word("after_rst", 32'hD, 1'b0);
    check("after_rst_head", 64'(out_instr), 64'hD);
    idle("mr_drain", 1'b1);

    // 7. Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 63) != 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle("final_drain", 1'b1);
    check("final_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
Parametrised successor to the single-entry instruction register: a DEPTH-entry instruction queue between instruction memory and decode.
- Captures instruction words, each tagged with its fetch PC, using a valid/ready handshake on both sides.
- Presents the oldest entry to decode.
- Supports a pipeline flush on branch/jump redirect.
- Presents the NOP word (all zeros) whenever empty, as the old IR does after reset.

Parameters:
DATA_W, 32, instruction word width in bits
PC_W, 32, fetch PC tag width in bits
DEPTH, 4, number of entries; power of two, at least 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk
flush  input  1  discard all stored entries (branch/jump redirect)
in_valid  input  1  fetch side presents a word
in_ready  output  1  buffer can accept a word this cycle
in_instr  input  DATA_W  instruction word from IM
in_pc  input  PC_W  PC of in_instr
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes head this cycle
out_instr  output  DATA_W  head instruction; 0 (NOP) when empty
out_pc  output  PC_W  head PC; 0 when empty
count  output  $clog2(DEPTH)+1  number of stored entries

Behaviour:
- Reset: rst=0 at a rising edge clears the write pointer, the read pointer and count. After that edge: out_valid=0, out_instr=0, out_pc=0, count=0, in_ready=1. Storage contents need not be cleared. Reset has priority over flush, push and pop, including when it arrives mid-stream.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is combinational from state only and does not depend on out_ready. When full, a same-cycle pop does not allow a push.
- Push: the word is written at wr_ptr and wr_ptr increments modulo DEPTH. Latency is 1 cycle: a word pushed into an empty buffer at edge N appears on out_* with out_valid=1 after edge N. There is no combinational path from in_* to out_*.
- Pop: rd_ptr increments modulo DEPTH. The next entry appears on out_* after the same edge.
- Simultaneous push and pop (count between 1 and DEPTH-1): both pointers advance and count is unchanged.
- Pop while empty is ignored, because out_valid=0 makes pop impossible.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
- out_valid = (count != 0).
- out_instr and out_pc show storage[rd_ptr] when out_valid=1; otherwise both are forced to 0.
- Flush (flush=1, rst=1): after the edge, count=0 and rd_ptr=wr_ptr, so out_valid=0. A push in the same cycle is dropped; the fetch side must re-fetch. A pop in the same cycle has no further effect.
- Push is not gated by flush in in_ready. The source sees the handshake complete, but the word is discarded.
- Decode stall: while out_ready=0, out_* hold stable across edges. Pushes continue until full.
- A rising edge with no push, no pop, no flush and rst=1 leaves all state unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_NOP constant (32'h00000000)
  - default DATA_W and PC_W
  - a clog2-based pointer-width helper constant
- One sub-module is natural: ibuf_mem, a DEPTH x (DATA_W+PC_W) register array with:
  - synchronous write port: we, waddr, wdata
  - asynchronous read port: raddr, rdata
  - no reset
- Pointers, count, handshake logic and output masking stay in instr_buffer.

Test Plan:
1. Reset/empty: hold rst=0 for 2 cycles with in_valid=1 and in_instr=32'h8C010004 -> out_valid=0, out_instr=0, count=0, in_ready=1. No entry is stored.
2. Single pass: push 32'h20080005 with pc=32'h00003000 at edge N, out_ready=0 -> after edge N out_valid=1, out_instr=32'h20080005, out_pc=32'h00003000, count=1. Raise out_ready for one cycle -> out_valid=0, out_instr=0.
3. Fill and wrap (DEPTH=4):
   - Push 0x1..0x4 with out_ready=0 -> count=4, in_ready=0. A 5th word 0x5 with in_valid=1 is not accepted.
   - Then pop 2 and push 0x5, 0x6 -> outputs in order 0x3, 0x4, 0x5, 0x6. Pointers wrap correctly.
4. Simultaneous push/pop at count=2: push 0xA while popping -> count stays 2, next out_instr is the second-oldest entry, and 0xA emerges after it.
5. Flush: with count=3, assert flush together with push of 0xBEEF -> after the edge count=0, out_valid=0, out_instr=0. 0xBEEF never appears. The next push of 0xC appears one cycle later.
6. Reset mid-operation: count=3 and out_ready=1, assert rst=0 for one edge -> count=0, out_valid=0. A following push of 0xD is the first word out.
